// File: rtl/mem_bus_responder_pkg.sv
// Shared types and constants for the memory bus responder: FSM state
// encoding, byte-lane enable patterns and the wait-state ceiling.
package mem_bus_pkg;

    localparam int MAX_WAIT_STATES = 15;

    localparam logic [1:0] LANE_NONE = 2'b00;
    localparam logic [1:0] LANE_LO   = 2'b01;
    localparam logic [1:0] LANE_HI   = 2'b10;
    localparam logic [1:0] LANE_ALL  = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_ACK     = 2'd2,
        ST_RECOVER = 2'd3
    } state_t;

endpackage

// File: rtl/mem_bus_responder_if.sv
// Initiator/responder memory bus. The master modport covers the initiator
// together with the external address decoder, which drives cs.
interface mem_bus_if;
    logic        cs;
    logic        m_access;
    logic [19:1] m_addr;
    logic        m_wr_en;
    logic [1:0]  m_bytesel;
    logic [15:0] m_data_wr;
    logic [15:0] m_data_rd;
    logic        m_ack;

    modport master (
        output cs, m_access, m_addr, m_wr_en, m_bytesel, m_data_wr,
        input  m_data_rd, m_ack
    );

    modport slave (
        input  cs, m_access, m_addr, m_wr_en, m_bytesel, m_data_wr,
        output m_data_rd, m_ack
    );
endinterface

// File: rtl/mem_bus_responder_bytewise_ram.sv
// Single-port 16-bit RAM with per-byte write enables and a registered read.
// Contents are never reset.
module bytewise_ram #(
    parameter int ADDR_BITS = 10
) (
    input  logic                 clk,
    input  logic [ADDR_BITS-1:0] addr,
    input  logic [1:0]           we,
    input  logic [15:0]          wdata,
    output logic [15:0]          rdata
);
    logic [15:0] mem [0:(2**ADDR_BITS)-1];

    always_ff @(posedge clk) begin
        if (we[0]) mem[addr][7:0]  <= wdata[7:0];
        if (we[1]) mem[addr][15:8] <= wdata[15:8];
        rdata <= mem[addr];
    end
endmodule

// File: rtl/mem_bus_responder.sv
// Wait-state memory bus responder in front of a byte-writable local RAM.
// Optional MEM_BUS_RESPONDER_STATS_EN adds saturating rd_count/wr_count outputs.
//
// state      | meaning
// ST_IDLE    | sampling cs & m_access; request latched on acceptance
// ST_WAIT    | burning WAIT_STATES cycles on the down-counter
// ST_ACK     | next edge raises m_ack, commits write / captures read data
// ST_RECOVER | ack cycle; bus ignored, returns to idle
module mem_bus_responder
    import mem_bus_pkg::*;
#(
    parameter int ADDR_BITS   = 10,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        reset,
    mem_bus_if.slave    bus
`ifdef MEM_BUS_RESPONDER_STATS_EN
    ,
    output logic [15:0] rd_count,
    output logic [15:0] wr_count
`endif
);
    if (WAIT_STATES < 0 || WAIT_STATES > MAX_WAIT_STATES) begin : g_bad_wait
        $error("mem_bus_responder: WAIT_STATES out of range 0..15");
    end

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    state_t                 state;
    logic [3:0]             wait_cnt;
    logic [ADDR_BITS-1:0]   addr_q;
    logic                   wr_en_q;
    logic [1:0]             bytesel_q;
    logic [15:0]            wdata_q;
    logic                   ack_q;
    logic [15:0]            data_rd_q;

    logic [ADDR_BITS-1:0]   ram_addr;
    logic [1:0]             ram_we;
    logic [15:0]            ram_rdata;
    logic                   accept;
    logic                   unused_addr;

    assign accept      = bus.cs & bus.m_access;
    assign unused_addr = ^bus.m_addr;

    // In idle the RAM looks at the live address so read data is ready even
    // with zero wait states; afterwards it tracks the latched address.
    assign ram_addr = (state == ST_IDLE) ? bus.m_addr[ADDR_BITS:1] : addr_q;
    assign ram_we   = (state == ST_ACK && wr_en_q && !reset) ? bytesel_q : LANE_NONE;

    bytewise_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
        .clk   (clk),
        .addr  (ram_addr),
        .we    (ram_we),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            wr_en_q   <= 1'b0;
            bytesel_q <= LANE_NONE;
            wdata_q   <= 16'h0000;
            ack_q     <= 1'b0;
            data_rd_q <= 16'h0000;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_q <= 1'b0;
                    if (accept) begin
                        addr_q    <= bus.m_addr[ADDR_BITS:1];
                        wr_en_q   <= bus.m_wr_en;
                        bytesel_q <= bus.m_bytesel;
                        wdata_q   <= bus.m_data_wr;
                        if (WAIT_STATES == 0) begin
                            state <= ST_ACK;
                        end else begin
                            wait_cnt <= WAIT_INIT;
                            state    <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    wait_cnt <= wait_cnt - 4'd1;
                    if (wait_cnt == 4'd1) state <= ST_ACK;
                end
                ST_ACK: begin
                    ack_q <= 1'b1;
                    if (!wr_en_q) data_rd_q <= ram_rdata;
                    state <= ST_RECOVER;
                end
                ST_RECOVER: begin
                    ack_q <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.m_ack     = ack_q;
    assign bus.m_data_rd = data_rd_q;

`ifdef MEM_BUS_RESPONDER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_count <= 16'h0000;
            wr_count <= 16'h0000;
        end else if (state == ST_ACK) begin
            if (wr_en_q) begin
                if (wr_count != 16'hFFFF) wr_count <= wr_count + 16'd1;
            end else begin
                if (rd_count != 16'hFFFF) rd_count <= rd_count + 16'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: one instance with WAIT_STATES=1, one with 0,
// checked against a scoreboard of expected acks and read data.
module tb_mem_bus_responder;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    mem_bus_if bus1 ();
    mem_bus_if bus0 ();

`ifdef MEM_BUS_RESPONDER_STATS_EN
    logic [15:0] rd_count1, wr_count1, rd_count0, wr_count0;
    mem_bus_responder #(.ADDR_BITS(10), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1), .rd_count(rd_count1), .wr_count(wr_count1));
    mem_bus_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0), .rd_count(rd_count0), .wr_count(wr_count0));
`else
    mem_bus_responder #(.ADDR_BITS(10), .WAIT_STATES(1)) dut1 (
        .clk(clk), .reset(reset), .bus(bus1));
    mem_bus_responder #(.ADDR_BITS(10), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset(reset), .bus(bus0));
`endif

    typedef struct {
        logic        is_rd;
        logic [15:0] data;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_rd[2];
    int   exp_wr[2];

    task automatic drive(input int sel, input logic cs, input logic acc, input logic wr,
                         input logic [19:1] addr, input logic [1:0] bs, input logic [15:0] wd);
        if (sel == 1) begin
            bus1.cs = cs; bus1.m_access = acc; bus1.m_wr_en = wr;
            bus1.m_addr = addr; bus1.m_bytesel = bs; bus1.m_data_wr = wd;
        end else begin
            bus0.cs = cs; bus0.m_access = acc; bus0.m_wr_en = wr;
            bus0.m_addr = addr; bus0.m_bytesel = bs; bus0.m_data_wr = wd;
        end
    endtask

    function automatic logic ack_of(input int sel);
        return (sel == 1) ? bus1.m_ack : bus0.m_ack;
    endfunction

    function automatic logic [15:0] rd_of(input int sel);
        return (sel == 1) ? bus1.m_data_rd : bus0.m_data_rd;
    endfunction

    // Called at a negedge with the DUT idle; returns at a negedge with the DUT idle.
    task automatic txn(input string name, input int sel, input logic wr, input logic [19:1] addr,
                       input logic [1:0] bs, input logic [15:0] wd, input logic [15:0] exp_data);
        exp_t e;
        int   k;
        int   ws;
        bit   seen;
        ws = (sel == 1) ? 1 : 0;
        e.is_rd = !wr;
        e.data  = exp_data;
        sb.push_back(e);
        if (wr) exp_wr[sel]++; else exp_rd[sel]++;
        drive(sel, 1'b1, 1'b1, wr, addr, bs, wd);
        k = 0;
        seen = 0;
        while (!seen && k < 40) begin
            @(posedge clk); k++;
            @(negedge clk);
            if (ack_of(sel)) seen = 1;
        end
        drive(sel, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s ack_timeout: no ack within 40 cycles", name);
            void'(sb.pop_front());
        end else begin
            e = sb.pop_front();
            checks++;
            if (k !== ws + 2) begin
                errors++;
                $display("FAIL %s ack_latency: got %0d edges, want %0d", name, k, ws + 2);
            end
            if (e.is_rd) begin
                checks++;
                if (rd_of(sel) !== e.data) begin
                    errors++;
                    $display("FAIL %s rd_data: got %h, want %h", name, rd_of(sel), e.data);
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (ack_of(sel) !== 1'b0) begin
            errors++;
            $display("FAIL %s ack_width: ack still %b one cycle later", name, ack_of(sel));
        end
    endtask

    task automatic check_stats(input string name);
`ifdef MEM_BUS_RESPONDER_STATS_EN
        checks++;
        if (rd_count1 !== 16'(exp_rd[1]) || wr_count1 !== 16'(exp_wr[1])) begin
            errors++;
            $display("FAIL %s stats1: got rd=%0d wr=%0d, want rd=%0d wr=%0d",
                     name, rd_count1, wr_count1, exp_rd[1], exp_wr[1]);
        end
        checks++;
        if (rd_count0 !== 16'(exp_rd[0]) || wr_count0 !== 16'(exp_wr[0])) begin
            errors++;
            $display("FAIL %s stats0: got rd=%0d wr=%0d, want rd=%0d wr=%0d",
                     name, rd_count0, wr_count0, exp_rd[0], exp_wr[0]);
        end
`else
        $display("stats counters not built (%s)", name);
`endif
    endtask

    task automatic test_reset();
        drive(1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        drive(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_rd = '{0, 0};
        exp_wr = '{0, 0};
        checks++;
        if (bus1.m_ack !== 1'b0 || bus0.m_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_ack: got %b/%b, want 0/0", bus1.m_ack, bus0.m_ack);
        end
        checks++;
        if (bus1.m_data_rd !== 16'h0000 || bus0.m_data_rd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_rd: got %h/%h, want 0000/0000", bus1.m_data_rd, bus0.m_data_rd);
        end
        check_stats("reset");
    endtask

    task automatic test_cs_low();
        int acks1 = 0;
        int acks0 = 0;
        drive(1, 1'b0, 1'b1, 1'b1, 19'h00010, 2'b11, 16'hDEAD);
        drive(0, 1'b0, 1'b1, 1'b0, 19'h00010, 2'b11, 16'h0000);
        repeat (20) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.m_ack) acks1++;
            if (bus0.m_ack) acks0++;
        end
        drive(1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        drive(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        checks++;
        if (acks1 != 0 || acks0 != 0) begin
            errors++;
            $display("FAIL cs_low_acks: got %0d/%0d acks, want 0/0", acks1, acks0);
        end
        check_stats("cs_low");
    endtask

    task automatic test_byte_lanes();
        txn("wr_beef",   1, 1'b1, 19'h00010, 2'b11, 16'hBEEF, 16'h0000);
        txn("rd_beef",   1, 1'b0, 19'h00010, 2'b00, 16'h0000, 16'hBEEF);
        txn("wr_hi",     1, 1'b1, 19'h00010, 2'b10, 16'h12AB, 16'h0000);
        checks++;
        if (bus1.m_data_rd !== 16'hBEEF) begin
            errors++;
            $display("FAIL rd_hold: got %h after write, want BEEF", bus1.m_data_rd);
        end
        txn("rd_12ef",   1, 1'b0, 19'h00010, 2'b01, 16'h0000, 16'h12EF);
        txn("wr_lo",     1, 1'b1, 19'h00010, 2'b01, 16'h0034, 16'h0000);
        txn("rd_1234",   1, 1'b0, 19'h00010, 2'b11, 16'h0000, 16'h1234);
        txn("wr_none",   1, 1'b1, 19'h00010, 2'b00, 16'hFFFF, 16'h0000);
        txn("rd_none",   1, 1'b0, 19'h00010, 2'b00, 16'h0000, 16'h1234);
    endtask

    task automatic test_alias();
        txn("wr_alias",  1, 1'b1, 19'h00400, 2'b11, 16'h5555, 16'h0000);
        txn("rd_alias0", 1, 1'b0, 19'h00000, 2'b11, 16'h0000, 16'h5555);
        txn("wr_base",   1, 1'b1, 19'h00000, 2'b11, 16'hA5C3, 16'h0000);
        txn("rd_alias1", 1, 1'b0, 19'h7FC00, 2'b11, 16'h0000, 16'hA5C3);
    endtask

    task automatic test_back_to_back();
        int   ack_cyc[$];
        int   cyc;
        int   nacks;
        exp_t e;
        logic [15:0] vals[3];
        vals[0] = 16'h1111;
        vals[1] = 16'h2222;
        vals[2] = 16'h3333;
        for (int i = 0; i < 3; i++)
            txn("b2b_fill", 0, 1'b1, 19'(i + 1), 2'b11, vals[i], 16'h0000);
        for (int i = 0; i < 3; i++) begin
            e.is_rd = 1'b1;
            e.data  = vals[i];
            sb.push_back(e);
            exp_rd[0]++;
        end
        cyc = 0;
        nacks = 0;
        drive(0, 1'b1, 1'b1, 1'b0, 19'h00001, 2'b11, 16'h0000);
        while (nacks < 3 && cyc < 40) begin
            @(posedge clk); cyc++;
            @(negedge clk);
            if (bus0.m_ack) begin
                ack_cyc.push_back(cyc);
                nacks++;
                e = sb.pop_front();
                checks++;
                if (bus0.m_data_rd !== e.data) begin
                    errors++;
                    $display("FAIL b2b_data%0d: got %h, want %h", nacks, bus0.m_data_rd, e.data);
                end
                if (nacks < 3) drive(0, 1'b1, 1'b1, 1'b0, 19'(nacks + 1), 2'b11, 16'h0000);
                else           drive(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
            end
        end
        drive(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        checks++;
        if (nacks != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d acks, want 3", nacks);
            while (sb.size() > 0) void'(sb.pop_front());
        end else begin
            for (int i = 1; i < 3; i++) begin
                checks++;
                if (ack_cyc[i] - ack_cyc[i-1] != 3) begin
                    errors++;
                    $display("FAIL b2b_spacing%0d: got %0d cycles, want 3", i, ack_cyc[i] - ack_cyc[i-1]);
                end
            end
        end
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (bus0.m_ack !== 1'b0) begin
                errors++;
                $display("FAIL b2b_extra_ack: ack seen after access dropped");
            end
        end
        check_stats("b2b");
    endtask

    task automatic test_reset_mid_write();
        int acks = 0;
        txn("wr_prior", 1, 1'b1, 19'h00020, 2'b11, 16'h0A0A, 16'h0000);
        check_stats("pre_abort");
        drive(1, 1'b1, 1'b1, 1'b1, 19'h00020, 2'b11, 16'hFFFF);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.m_ack) acks++;
        end
        reset = 1'b0;
        exp_rd = '{0, 0};
        exp_wr = '{0, 0};
        checks++;
        if (bus1.m_data_rd !== 16'h0000) begin
            errors++;
            $display("FAIL abort_rd_cleared: got %h, want 0000", bus1.m_data_rd);
        end
        repeat (4) begin
            @(posedge clk);
            @(negedge clk);
            if (bus1.m_ack) acks++;
        end
        checks++;
        if (acks != 0) begin
            errors++;
            $display("FAIL abort_no_ack: got %0d acks, want 0", acks);
        end
        txn("rd_prior", 1, 1'b0, 19'h00020, 2'b11, 16'h0000, 16'h0A0A);
        check_stats("post_abort");
    endtask

    initial begin
        exp_rd = '{0, 0};
        exp_wr = '{0, 0};
        reset = 1'b1;
        drive(1, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        drive(0, 1'b0, 1'b0, 1'b0, '0, 2'b00, 16'h0000);
        @(negedge clk);
        test_reset();
        test_cs_low();
        test_byte_lanes();
        test_alias();
        check_stats("after_ws1");
        test_back_to_back();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
